// File: rtl/mano_pkg.sv
// Shared constants and types for the Mano-style accumulator core:
// opcodes, register-op selects, T-state numbering and the run-state enum.
package mano_pkg;

  localparam logic [2:0] OP_LDA = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_JMP = 3'd4;
  localparam logic [2:0] OP_BZ  = 3'd5;
  localparam logic [2:0] OP_REG = 3'd6;
  localparam logic [2:0] OP_HLT = 3'd7;

  localparam logic [1:0] RO_CLA = 2'd0;
  localparam logic [1:0] RO_CMA = 2'd1;
  localparam logic [1:0] RO_INC = 2'd2;
  localparam logic [1:0] RO_OUT = 2'd3;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  typedef enum logic {
    S_HALT = 1'b0,
    S_RUN  = 1'b1
  } run_state_e;

  // LDA, ADD and AND fetch a memory operand and therefore need T4.
  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_AND);
  endfunction

endpackage

// File: rtl/mano_if.sv
// Control, load and observation bundle of the Mano core; the core is the
// slave, whoever drives run/step/load is the master.
interface mano_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              run;
  logic              step;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] acc;
  logic              e_flag;
  logic [ADDR_W-1:0] pc;
  logic [2:0]        t_state;
  logic              halted;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;

  modport master (
    output run, step, ld_we, ld_addr, ld_data,
    input  acc, e_flag, pc, t_state, halted, out_data, out_valid
  );

  modport slave (
    input  run, step, ld_we, ld_addr, ld_data,
    output acc, e_flag, pc, t_state, halted, out_data, out_valid
  );
endinterface

// File: rtl/mano_ram.sv
// Single-port word-addressed RAM with a registered read; contents are never
// reset so a loaded program survives a core reset.
module mano_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_r;

  // Write-then-register-read; a read issued in a write cycle returns old data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    rdata_r <= mem_r[addr];
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mano_cpu_core.sv
// Accumulator CPU core: HALT/RUN control with free-run and single-step modes,
// T0..T4 instruction sequencing and an internal RAM loaded while halted.
module mano_cpu_core
  import mano_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic  clk,
  input  logic  rst,
  mano_if.slave bus
);

  run_state_e        state_r;
  logic              step_mode_r;
  logic              halted_r;
  logic [2:0]        t_r;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] mar_r;
  logic [DATA_W-1:0] mbr_r;
  logic [DATA_W-1:0] ir_r;
  logic [DATA_W-1:0] acc_r;
  logic              e_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_valid_r;

  logic [2:0]        op_s;
  logic [1:0]        ro_s;
  logic [ADDR_W-1:0] ir_addr_s;
  logic              end_s;
  logic              halt_now_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic [DATA_W-1:0] ram_rdata_s;

  assign op_s      = ir_r[DATA_W-1 -: 3];
  assign ro_s      = ir_r[1:0];
  assign ir_addr_s = ir_r[ADDR_W-1:0];

  mano_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_s),
    .addr (ram_addr_s),
    .wdata(ram_wdata_s),
    .rdata(ram_rdata_s)
  );

  // RAM port mux: the address is presented one edge early so read data
  // lines up with the T-state that consumes it; reset blocks every write.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_addr_s  = mar_r;
    ram_wdata_s = acc_r;
    if (rst) begin
      ram_we_s = 1'b0;
    end else if (state_r == S_HALT) begin
      if (bus.ld_we) begin
        ram_we_s    = 1'b1;
        ram_addr_s  = bus.ld_addr;
        ram_wdata_s = bus.ld_data;
      end else begin
        ram_addr_s = pc_r;
      end
    end else begin
      case (t_r)
        T0:      ram_addr_s = pc_r;
        T2:      ram_addr_s = mbr_r[ADDR_W-1:0];
        T3: begin
          if (op_s == OP_STA) begin
            ram_we_s = 1'b1;
          end else begin
            ram_we_s = 1'b0;
          end
        end
        default: ram_addr_s = mar_r;
      endcase
    end
  end

  // End-of-instruction and halt decode for the current T-state.
  always_comb begin
    end_s      = 1'b0;
    halt_now_s = 1'b0;
    if (state_r == S_RUN) begin
      case (t_r)
        T0, T1, T2: end_s = 1'b0;
        T3: begin
          if (op_s == OP_HLT) begin
            halt_now_s = 1'b1;
          end else if (is_mem_op(op_s)) begin
            end_s = 1'b0;
          end else begin
            end_s = 1'b1;
          end
        end
        T4:      end_s      = 1'b1;
        default: halt_now_s = 1'b1;
      endcase
    end else begin
      end_s      = 1'b0;
      halt_now_s = 1'b0;
    end
  end

  // Run-state machine and architectural registers, one T-state per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_HALT;
      step_mode_r <= 1'b0;
      halted_r    <= 1'b1;
      t_r         <= T0;
      pc_r        <= {ADDR_W{1'b0}};
      mar_r       <= {ADDR_W{1'b0}};
      mbr_r       <= {DATA_W{1'b0}};
      ir_r        <= {DATA_W{1'b0}};
      acc_r       <= {DATA_W{1'b0}};
      e_r         <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        S_HALT: begin
          t_r <= T0;
          if (bus.ld_we) begin
            halted_r <= 1'b1;
          end else if (bus.step) begin
            state_r     <= S_RUN;
            step_mode_r <= 1'b1;
            halted_r    <= 1'b0;
          end else if (bus.run) begin
            state_r     <= S_RUN;
            step_mode_r <= 1'b0;
            halted_r    <= 1'b0;
          end else begin
            halted_r <= 1'b1;
          end
        end
        S_RUN: begin
          case (t_r)
            T0: mar_r <= pc_r;
            T1: begin
              mbr_r <= ram_rdata_s;
              pc_r  <= pc_r + ADDR_W'(1'b1);
            end
            T2: begin
              ir_r  <= mbr_r;
              mar_r <= mbr_r[ADDR_W-1:0];
            end
            T3: begin
              case (op_s)
                OP_LDA, OP_ADD, OP_AND: mbr_r <= ram_rdata_s;
                OP_JMP: pc_r <= ir_addr_s;
                OP_BZ: begin
                  if (acc_r == {DATA_W{1'b0}}) begin
                    pc_r <= ir_addr_s;
                  end
                end
                OP_REG: begin
                  case (ro_s)
                    RO_CLA:  acc_r <= {DATA_W{1'b0}};
                    RO_CMA:  acc_r <= ~acc_r;
                    RO_INC:  {e_r, acc_r} <= {1'b0, acc_r} + (DATA_W+1)'(1'b1);
                    RO_OUT: begin
                      out_data_r  <= acc_r;
                      out_valid_r <= 1'b1;
                    end
                    default: acc_r <= acc_r;
                  endcase
                end
                default: acc_r <= acc_r;
              endcase
            end
            T4: begin
              case (op_s)
                OP_LDA:  acc_r <= mbr_r;
                OP_ADD:  {e_r, acc_r} <= {1'b0, acc_r} + {1'b0, mbr_r};
                OP_AND:  acc_r <= acc_r & mbr_r;
                default: acc_r <= acc_r;
              endcase
            end
            default: acc_r <= acc_r;
          endcase

          if (halt_now_s || (end_s && step_mode_r)) begin
            state_r     <= S_HALT;
            step_mode_r <= 1'b0;
            halted_r    <= 1'b1;
            t_r         <= T0;
          end else if (end_s) begin
            t_r <= T0;
          end else begin
            t_r <= t_r + 3'd1;
          end
        end
        default: begin
          state_r  <= S_HALT;
          halted_r <= 1'b1;
          t_r      <= T0;
        end
      endcase
    end
  end

  assign bus.acc       = acc_r;
  assign bus.e_flag    = e_r;
  assign bus.pc        = pc_r;
  assign bus.t_state   = t_r;
  assign bus.halted    = halted_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_mano_cpu_core.sv
// Self-checking bench for mano_cpu_core: directed programs plus random
// single-step runs compared against an instruction-level reference model.
module tb_mano_cpu_core;

  logic clk;
  logic rst;

  mano_if #(.DATA_W(8), .ADDR_W(5)) bus ();

  mano_cpu_core #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_n = 0;
  int fails_n  = 0;

  // Reference model: whole-instruction semantics only.
  logic [7:0] m_mem [32];
  logic [7:0] m_acc;
  logic       m_e;
  logic [4:0] m_pc;
  int         m_outs;
  logic [7:0] m_out_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      fails_n++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_exec(output int cyc, output bit hlt);
    logic [7:0] ir;
    logic [8:0] sum;
    logic [4:0] ad;
    ir  = m_mem[m_pc];
    m_pc = m_pc + 5'd1;
    ad  = ir[4:0];
    hlt = 1'b0;
    cyc = (ir[7:5] <= 3'd2) ? 5 : 4;
    case (ir[7:5])
      3'd0: m_acc = m_mem[ad];
      3'd1: begin sum = m_acc + m_mem[ad]; m_acc = sum[7:0]; m_e = sum[8]; end
      3'd2: m_acc = m_acc & m_mem[ad];
      3'd3: m_mem[ad] = m_acc;
      3'd4: m_pc = ad;
      3'd5: if (m_acc == 8'd0) m_pc = ad;
      3'd6: begin
        case (ir[1:0])
          2'd0: m_acc = 8'd0;
          2'd1: m_acc = ~m_acc;
          2'd2: begin sum = m_acc + 9'd1; m_acc = sum[7:0]; m_e = sum[8]; end
          default: begin m_outs++; m_out_data = m_acc; end
        endcase
      end
      default: hlt = 1'b1;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.run = 1'b0; bus.step = 1'b0; bus.ld_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_acc = 8'd0; m_e = 1'b0; m_pc = 5'd0; m_out_data = 8'd0;
  endtask

  task automatic load_word(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.ld_we = 1'b1; bus.ld_addr = a; bus.ld_data = d;
    @(negedge clk);
    bus.ld_we = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic mem_chk(input string tag);
    for (int a = 0; a < 32; a++) chk($sformatf("%s_mem%0d", tag, a), dut.u_ram.mem_r[a], m_mem[a]);
  endtask

  task automatic state_chk(input string tag);
    chk({tag, "_acc"}, bus.acc, m_acc);
    chk({tag, "_e"}, bus.e_flag, m_e);
    chk({tag, "_pc"}, bus.pc, m_pc);
    chk({tag, "_t"}, bus.t_state, 3'd0);
    chk({tag, "_halted"}, bus.halted, 1'b1);
    chk({tag, "_outdata"}, bus.out_data, m_out_data);
  endtask

  // Wait for halted with a cycle budget, counting out_valid pulses on the way.
  task automatic wait_halt(input int budget, output int cyc, output int outs);
    cyc = 0; outs = 0;
    while (!bus.halted && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) outs++;
    end
  endtask

  task automatic do_step(input bit with_run, input string tag);
    int exp_cyc, cyc, outs, outs0;
    bit hlt;
    outs0 = m_outs;
    m_exec(exp_cyc, hlt);
    @(negedge clk);
    bus.step = 1'b1; bus.run = with_run;
    @(negedge clk);
    bus.step = 1'b0; bus.run = 1'b0;
    wait_halt(12, cyc, outs);
    chk({tag, "_cyc"}, cyc, exp_cyc);
    chk({tag, "_outs"}, outs, m_outs - outs0);
    state_chk(tag);
  endtask

  task automatic do_run(input string tag);
    int exp_cyc, c, cyc, outs, outs0;
    bit hlt;
    outs0 = m_outs; exp_cyc = 0; hlt = 1'b0;
    for (int i = 0; i < 200 && !hlt; i++) begin
      m_exec(c, hlt);
      exp_cyc += c;
    end
    @(negedge clk);
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    wait_halt(exp_cyc + 10, cyc, outs);
    chk({tag, "_cyc"}, cyc, exp_cyc);
    chk({tag, "_outs"}, outs, m_outs - outs0);
    state_chk(tag);
  endtask

  initial begin
    rst = 1'b1; bus.run = 1'b0; bus.step = 1'b0; bus.ld_we = 1'b0;
    bus.ld_addr = 5'd0; bus.ld_data = 8'd0; m_outs = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_acc = 8'd0; m_e = 1'b0; m_pc = 5'd0; m_out_data = 8'd0;

    chk("rst_acc", bus.acc, 8'd0);
    chk("rst_e", bus.e_flag, 1'b0);
    chk("rst_pc", bus.pc, 5'd0);
    chk("rst_t", bus.t_state, 3'd0);
    chk("rst_halted", bus.halted, 1'b1);
    chk("rst_outdata", bus.out_data, 8'd0);
    chk("rst_outvalid", bus.out_valid, 1'b0);

    for (int a = 0; a < 32; a++) load_word(a[4:0], 8'($urandom));

    // LDA/ADD/STA/HLT program.
    do_reset();
    load_word(5'd0, 8'h0A); load_word(5'd1, 8'h2B); load_word(5'd2, 8'h6C);
    load_word(5'd3, 8'hE0); load_word(5'd10, 8'h25); load_word(5'd11, 8'h1C);
    do_run("prog1");
    chk("prog1_acc_lit", bus.acc, 8'h41);
    chk("prog1_mem12_lit", dut.u_ram.mem_r[12], 8'h41);
    chk("prog1_pc_lit", bus.pc, 5'd4);
    mem_chk("prog1");

    // ADD carry out.
    do_reset();
    load_word(5'd0, 8'h0A); load_word(5'd1, 8'h2B); load_word(5'd2, 8'hE0);
    load_word(5'd10, 8'hF0); load_word(5'd11, 8'h20);
    do_run("addov");
    chk("addov_acc_lit", bus.acc, 8'h10);
    chk("addov_e_lit", bus.e_flag, 1'b1);

    // INC carry out.
    do_reset();
    load_word(5'd0, 8'h0C); load_word(5'd1, 8'hC2); load_word(5'd2, 8'hE0);
    load_word(5'd12, 8'hFF);
    do_run("inc");
    chk("inc_acc_lit", bus.acc, 8'h00);
    chk("inc_e_lit", bus.e_flag, 1'b1);

    // BZ taken / not taken, OUT pulse.
    do_reset();
    load_word(5'd0, 8'hC0); load_word(5'd1, 8'hA5); load_word(5'd5, 8'hC1);
    load_word(5'd6, 8'hA0); load_word(5'd7, 8'hC3); load_word(5'd8, 8'hE0);
    do_run("bz");
    chk("bz_outdata_lit", bus.out_data, 8'hFF);
    @(negedge clk);
    chk("bz_outvalid_low", bus.out_valid, 1'b0);

    // Single-step LDA/ADD/HLT.
    do_reset();
    load_word(5'd0, 8'h0A); load_word(5'd1, 8'h2B); load_word(5'd2, 8'hE0);
    do_step(1'b0, "step1"); chk("step1_pc_lit", bus.pc, 5'd1);
    do_step(1'b0, "step2"); chk("step2_pc_lit", bus.pc, 5'd2);
    do_step(1'b1, "step3"); chk("step3_pc_lit", bus.pc, 5'd3);

    // PC wrap through address 31.
    do_reset();
    load_word(5'd0, 8'h9F); load_word(5'd31, 8'hC2);
    do_step(1'b0, "wrap_jmp");
    do_step(1'b0, "wrap_inc");
    chk("wrap_pc_lit", bus.pc, 5'd0);
    do_step(1'b0, "wrap_refetch");

    // Load has priority over run while halted.
    @(negedge clk);
    bus.ld_we = 1'b1; bus.run = 1'b1; bus.ld_addr = 5'd21; bus.ld_data = 8'h3C;
    @(negedge clk);
    bus.ld_we = 1'b0; bus.run = 1'b0; m_mem[21] = 8'h3C;
    @(negedge clk);
    chk("ldprio_halted", bus.halted, 1'b1);
    chk("ldprio_mem", dut.u_ram.mem_r[21], 8'h3C);

    // Reset at T3 of STA suppresses the write.
    do_reset();
    load_word(5'd0, 8'h6C); load_word(5'd12, 8'h5A);
    @(negedge clk); bus.run = 1'b1;
    @(negedge clk); bus.run = 1'b0;
    repeat (3) @(negedge clk);
    chk("starst_t3", bus.t_state, 3'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_acc = 8'd0; m_e = 1'b0; m_pc = 5'd0; m_out_data = 8'd0;
    chk("starst_mem12", dut.u_ram.mem_r[12], 8'h5A);
    chk("starst_outvalid", bus.out_valid, 1'b0);
    state_chk("starst");

    // Load strobe ignored while running.
    do_reset();
    load_word(5'd0, 8'h80);
    @(negedge clk); bus.run = 1'b1;
    @(negedge clk); bus.run = 1'b0;
    repeat (3) @(negedge clk);
    bus.ld_we = 1'b1; bus.ld_addr = 5'd20; bus.ld_data = ~m_mem[20];
    @(negedge clk);
    bus.ld_we = 1'b0;
    chk("ldrun_halted", bus.halted, 1'b0);
    do_reset();
    mem_chk("ldrun");

    // Random programs, single-stepped against the model.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int a = 0; a < 32; a++) load_word(a[4:0], 8'($urandom));
      for (int s = 0; s < 25; s++) do_step($urandom_range(0, 3) == 0, $sformatf("rnd%0d_%0d", r, s));
      mem_chk($sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout checks=%0d", checks_n);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mano_cpu_core.md
Name: mano_cpu_core

Overview:
Parametrised accumulator CPU core in the Mano basic-computer style. It is the successor to the fixed 8-bit fetch-only sequencer and executes a real instruction set end to end.
- Architectural state: PC, MAR, MBR, IR, A and the E (carry) flag.
- Memory: internal word-addressed RAM, loaded through a side port while the core is halted.
- Control: a T-state timing counter.
- Run modes: free-run and single-step. A sits on the TT output pins.

Parameters:
DATA_W, 8, word width of A, MBR, IR and memory words; must be at least ADDR_W+3.
ADDR_W, 5, address width of PC and MAR; memory depth is 2**ADDR_W.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
run  in  1  pulse while halted: start free-running from the current PC
step  in  1  pulse while halted: execute exactly one instruction, then halt
ld_we  in  1  memory load strobe; honoured only while halted
ld_addr  in  ADDR_W  load address
ld_data  in  DATA_W  load data
acc  out  DATA_W  accumulator A
e_flag  out  1  carry flag E
pc  out  ADDR_W  program counter
t_state  out  3  current T-state (0..4)
halted  out  1  core is idle
out_data  out  DATA_W  value latched by OUT
out_valid  out  1  one-cycle pulse when out_data updates

Behaviour:
Instruction format and opcodes:
- opcode = IR[DATA_W-1:DATA_W-3]; address field = IR[ADDR_W-1:0].
- 000 LDA; 001 ADD; 010 AND; 011 STA; 100 JMP; 101 BZ (branch if A==0).
- 110 register op, selected by IR[1:0]: 00 CLA, 01 CMA, 10 INC, 11 OUT.
- 111 HLT.

Reset (rst high at a clk edge):
- PC, MAR, MBR, IR, A, E, t_state, out_data all = 0.
- out_valid = 0; halted = 1; step-mode flag cleared.
- Memory contents are NOT reset.
- Reset mid-instruction aborts it. A pending STA that has not reached its T3 edge does not write.

Top-level FSM, states HALT and RUN:
- HALT + run=1 -> RUN, t_state=0, free-run.
- HALT + step=1 -> RUN with single-step flag set. After the instruction completes, return to HALT.
- run and step together: step wins.
- ld_we=1 in HALT writes mem[ld_addr] <= ld_data. It has priority: run and step are ignored in that cycle.
- ld_we, run and step are all ignored in RUN.

Per-instruction timing (one T-state per clk):
- T0: MAR <= PC.
- T1: MBR <= mem[MAR]; PC <= PC+1, wrapping modulo 2**ADDR_W.
- T2: IR <= MBR; MAR <= MBR[ADDR_W-1:0].
- T3, per opcode:
  - LDA, ADD, AND: MBR <= mem[MAR]; go to T4.
  - STA: mem[MAR] <= A; end.
  - JMP: PC <= addr; end.
  - BZ: if A==0 then PC <= addr; end.
  - CLA: A <= 0. CMA: A <= ~A. INC: {E,A} <= A+1. OUT: out_data <= A, out_valid=1 for this cycle only. Each ends the instruction.
  - HLT: go to HALT; PC stays at HLT address+1; end.
- T4, then end:
  - LDA: A <= MBR.
  - ADD: {E,A} <= A+MBR (DATA_W+1-bit sum).
  - AND: A <= A & MBR.

Instruction length and end of instruction:
- "End" means t_state <= 0; in single-step mode it also means go to HALT.
- Memory-operand ops (LDA/ADD/AND) take 5 clk; all others take 4.

Carry flag:
- E is changed only by ADD and INC; every other instruction leaves it unchanged.

Memory timing:
- Memory read is synchronous: data is valid in the cycle after MAR is registered.
- STA to the address being fetched next is visible to that next fetch.

Decomposition:
- Package mano_pkg holds:
  - opcode localparams (OP_LDA..OP_HLT) and register-op selects (RO_CLA..RO_OUT);
  - T-state constants T0..T4;
  - the run-state enum {S_HALT, S_RUN}.
- Sub-module mano_ram: single-port synchronous RAM parametrised by DATA_W and ADDR_W. It has one write port, muxed between the load port and STA, and one registered read.

Test Plan:
- Load mem[0]=LDA 10, mem[1]=ADD 11, mem[2]=STA 12, mem[3]=HLT, mem[10]=0x25, mem[11]=0x1C; pulse run -> halted after 5+5+4+4=18 clk; acc=0x41, mem[12]=0x41, e_flag=0, pc=4.
- ADD overflow: A=0xF0 plus mem=0x20 -> acc=0x10, e_flag=1. Then INC with A=0xFF -> acc=0x00, e_flag=1.
- BZ/JMP loop: CLA; BZ 5 taken -> pc=5. At 5: CMA; BZ 0 not taken; OUT -> out_valid high for exactly 1 clk with out_data=0xFF.
- Single step: program LDA/ADD/HLT; pulse step three times -> halted after each instruction. t_state=0 and pc = 1, 2, 3 respectively.
- PC wrap: JMP 31 with ADDR_W=5, mem[31]=INC -> next fetch from address 0.
- Reset at T3 of STA -> target word unchanged; all outputs zero, halted=1. ld_we asserted during RUN -> memory unchanged.
